alog_share_arb: RTL and testbench
=================================

# alog_share_arb

Round-robin scheduler that shares one antilog (log-domain to linear) converter between `NREQ` requesters in the HBO-TFLAF LUT-less datapath. Each requester offers an 18-bit signed log-domain word with a valid/ready handshake. The block grants one request per cycle, pushes it through a two-stage registered antilog pipeline with full backpressure, and returns the 19-bit linear result tagged with the requester index. It sits between the log-domain multiplier lanes and the weight-update accumulators, replacing per-lane antilog units.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, $clog2(NREQ): requester-index width (derived, not overridden).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  bit i: requester i offers `req_data[i]`.
- `req_data`  in  NREQ*18  packed; slice i = bits [18*i+17 : 18*i]; signed, integer exponent [17:12], fraction [11:0].
- `req_ready`  out  NREQ  one-hot or zero; bit i high means the word is taken this cycle.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  19  linear result, (1,18) unsigned format.
- `out_id`  out  IDW  index of the requester that produced `out_data`.
- `out_zero`  out  1  exponent was out of range; `out_data` is forced to 0.
- `busy`  out  1  either pipeline stage holds valid data.

## Operation
- Arbiter: round-robin pointer `ptr`, reset to 0. The grant goes to the first i with `req_valid[i]`, searching `ptr`, `ptr`+1, … mod NREQ. On acceptance, `ptr` ← granted+1 mod NREQ. With no acceptance, `ptr` holds.
- `advance` = !`out_valid` || `out_ready`. Stage 1 may load only when `advance` is high, or when stage 1 is empty.
- `req_ready[g]` = grant[g] && (stage-1 empty || `advance`). All other bits are 0. `req_ready` depends combinationally on `req_valid`; it never depends on `req_data`.
- Stage 1 registers the granted word, its id, and a valid bit.
- Stage 2 registers the antilog of the stage-1 word, plus id, zero flag and valid bit. Stage 2 drives the outputs.
- Antilog, with F = {1, data[11:0]} (13 bits) and E = data[17:12]:
  - E = 0: result = F << 6.
  - E = −k, k = 1..18: result = (F << 6) >> k, with right-shifted bits truncated.
  - Any other E (positive, or below −18): result = 0 and `out_zero` = 1.
- Outputs hold stable while `out_valid` && !`out_ready`.
- Reset values: `out_valid`=0, `out_data`=0, `out_id`=0, `out_zero`=0, `busy`=0, `req_ready`=0, `ptr`=0, both stage valid bits 0.

## Timing
- Latency: a word accepted in cycle t appears with `out_valid` in cycle t+2 if there is no stall.
- Throughput: one result per cycle with `out_ready` held high.
- Stall: with stage 2 full and `out_ready` low:
  - stage 1 holds its word;
  - a new word is accepted only if stage 1 is empty;
  - after that, `req_ready` is 0 until `out_ready` rises.
- Simultaneous: all NREQ valid in the same cycle are served in strict rotation, one per cycle, with no requester skipped.
- Requester drops `req_valid` without handshake: allowed; no state changes.
- `rst` mid-operation: in-flight words are discarded; outputs reach reset values on the next edge, regardless of `out_ready`.

## Structure
- Shared package `flaf_pkg`:
  - `LOG_W`=18, `LIN_W`=19, `FRAC_W`=12, `EXP_MIN`=−18.
  - typedef `log_word_t` (signed 18-bit).
- Sub-module: the existing combinational antilog converter `alog18`, instantiated once between stage 1 and stage 2.
- Arbiter and pointer logic stay inline.

## Test plan
- Single requester 0, `req_data`=18'h00000 → `out_data`=19'h40000, `out_id`=0, `out_zero`=0, two cycles after acceptance.
- Requester 2, 18'h3F800 (E=−1, frac 0x800) → 19'h30000. Requester 1, 18'h2E000 (E=−18) → 19'h00001. Requester 3, 18'h01000 (E=+1) → 19'h0, `out_zero`=1.
- All four valid continuously, `out_ready`=1 → `req_ready` order 0,1,2,3,0,…; `out_id` follows the same order two cycles later; one result per cycle.
- Backpressure: `out_ready`=0 for 5 cycles with all valid → exactly one extra word accepted (stage 1 fills); `out_data`/`out_id` stable. On release, results resume in order with no loss or duplication.
- Reset asserted while both stages are full → next cycle `out_valid`=0, `busy`=0, `ptr`=0; the first grant afterwards goes to requester 0.
- Randomized valid/ready against a reference antilog model over 10k words → every accepted word produces exactly one correct, correctly-tagged output.

Source files
------------

// File: rtl/flaf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flaf_pkg
//  Description : Shared widths and types for the HBO-TFLAF log-domain datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package flaf_pkg;

   localparam int LOG_W   = 18;              // log-domain word width
   localparam int LIN_W   = 19;              // linear result width, (1,18) unsigned
   localparam int FRAC_W  = 12;              // fractional bits of the log word
   localparam int EXP_W   = LOG_W - FRAC_W;  // integer exponent bits
   localparam int EXP_MIN = -18;             // most negative exponent still representable

   typedef logic signed [LOG_W-1:0] log_word_t;
   typedef logic        [LIN_W-1:0] lin_word_t;

endpackage : flaf_pkg
`default_nettype wire

// File: rtl/alog18.sv
`default_nettype none
// ============================================================================
//  Module      : alog18
//  Description : Combinational antilog converter. Maps an 18-bit signed
//                log-domain word to a 19-bit (1,18) linear value. Exponents
//                above 0 or below EXP_MIN give 0 with the zero flag set.
//  Revision    : 1.0  initial release
// ============================================================================
module alog18
   import flaf_pkg::*;
(
   input  log_word_t din,
   output lin_word_t dout,
   output logic      zero
);

   localparam logic signed [EXP_W-1:0] E_MIN = EXP_W'(EXP_MIN);

   logic signed [EXP_W-1:0] e;
   logic        [EXP_W-1:0] neg_e;
   logic        [LIN_W-1:0] mant;
   logic                    in_range;

   // Align {1,frac} to the (1,18) output format, then shift right by -E.
   always_comb begin
      e        = din[LOG_W-1:FRAC_W];
      neg_e    = -e;
      mant     = {1'b1, din[FRAC_W-1:0], {(LIN_W-1-FRAC_W){1'b0}}};
      in_range = (e[EXP_W-1] || (e == '0)) && (e >= E_MIN);
      dout     = in_range ? (mant >> neg_e) : '0;
      zero     = !in_range;
   end

endmodule : alog18
`default_nettype wire

// File: rtl/alog_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : alog_share_arb
//  Description : Round-robin scheduler sharing one antilog converter between
//                NREQ requesters. One grant per cycle into a two-stage
//                registered pipeline with full backpressure; results are
//                tagged with the originating requester index.
//  Revision    : 1.0  initial release
// ============================================================================
module alog_share_arb
   import flaf_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*LOG_W-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LIN_W-1:0]      out_data,
   output logic [IDW-1:0]        out_id,
   output logic                  out_zero,
   output logic                  busy
);

   log_word_t      req_word [NREQ];

   logic [IDW-1:0] ptr;
   logic           grant_vld;
   logic [IDW-1:0] grant_id;
   logic           advance;
   logic           s1_load;
   logic           accept;

   logic           s1_valid;
   log_word_t      s1_data;
   logic [IDW-1:0] s1_id;

   lin_word_t      alog_res;
   logic           alog_zero;

   logic           s2_valid;
   lin_word_t      s2_data;
   logic [IDW-1:0] s2_id;
   logic           s2_zero;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign req_word[i] = req_data[i*LOG_W +: LOG_W];
   end

   // Round-robin search: first valid requester starting at ptr, wrapping.
   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int off = 0; off < NREQ; off++) begin
         idx = int'(ptr) + off;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!grant_vld && req_valid[IDW'(idx)]) begin
            grant_vld = 1'b1;
            grant_id  = IDW'(idx);
         end
      end
   end

   // Stage 2 moves when it is empty or being drained; stage 1 may also fill
   // into an empty slot while stage 2 is stalled.
   assign advance   = !s2_valid || out_ready;
   assign s1_load   = !s1_valid || advance;
   assign accept    = grant_vld && s1_load && !rst;
   assign req_ready = accept ? (NREQ'(1) << grant_id) : '0;

   // Pointer moves just past the requester that was actually taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (accept) begin
         ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
      end
   end

   // Stage 1: captures the granted word and its requester index.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_id    <= '0;
      end else if (s1_load) begin
         s1_valid <= grant_vld;
         if (grant_vld) begin
            s1_data <= req_word[grant_id];
            s1_id   <= grant_id;
         end
      end
   end

   alog18 u_alog18 (
      .din  (s1_data),
      .dout (alog_res),
      .zero (alog_zero)
   );

   // Stage 2: registers the converted value; holds while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_id    <= '0;
         s2_zero  <= 1'b0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data <= alog_res;
            s2_id   <= s1_id;
            s2_zero <= alog_zero;
         end
      end
   end

   assign out_valid = s2_valid;
   assign out_data  = s2_data;
   assign out_id    = s2_id;
   assign out_zero  = s2_zero;
   assign busy      = s1_valid || s2_valid;

endmodule : alog_share_arb
`default_nettype wire

// File: tb/tb_alog_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alog_share_arb
//  Description : Self-checking bench for the shared antilog scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alog_share_arb;

   localparam int NREQ   = 4;
   localparam int NWORDS = 10000;
   localparam int LIMIT  = 60000;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [71:0] req_data  = '0;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [18:0] out_data;
   logic [1:0]  out_id;
   logic        out_zero;
   logic        busy;

   int total = 0;
   int bad   = 0;

   // Words used by the directed scenarios and their hand-computed results.
   logic [17:0] wtab [4] = '{18'h00000, 18'h3F800, 18'h3E000, 18'h01000};
   logic [18:0] etab [4] = '{19'h40000, 19'h30000, 19'h10000, 19'h00000};
   logic        ztab [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   always #5 clk = ~clk;

   alog_share_arb #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_zero  (out_zero),
      .busy      (busy)
   );

   task automatic set_word(input int i, input logic [17:0] d);
      req_data[i*18 +: 18] = d;
   endtask

   task automatic load_table();
      for (int i = 0; i < 4; i++) set_word(i, wtab[i]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      req_valid = '0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Independent antilog reference: {zero, value}.
   function automatic logic [19:0] ref_alog(input logic [17:0] d);
      int     e;
      longint v;
      e = int'(d[17:12]);
      if (e >= 32) e = e - 64;
      if (e > 0 || e < -18) return {1'b1, 19'h0};
      v = (longint'(d[11:0]) + 64'd4096) * 64;
      v = v / (longint'(1) << (-e));
      return {1'b0, v[18:0]};
   endfunction

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = 4'hF;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++;
      if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_req_ready got=%h want=0", req_ready); end
      total++;
      if (out_data !== 19'h0 || out_id !== 2'd0 || out_zero !== 1'b0) begin
         bad++; $display("FAIL reset_out_regs got data=%h id=%0d zero=%b want 0/0/0", out_data, out_id, out_zero);
      end
      do_reset();
   endtask

   task automatic test_single();
      int          ids  [4] = '{0, 2, 1, 3};
      logic [17:0] dats [4] = '{18'h00000, 18'h3F800, 18'h2E000, 18'h01000};
      logic [18:0] exps [4] = '{19'h40000, 19'h30000, 19'h00001, 19'h00000};
      logic        zers [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [3:0]  oh;
      do_reset();
      for (int v = 0; v < 4; v++) begin
         oh = 4'b0001 << ids[v];
         @(negedge clk);
         req_valid = oh;
         set_word(ids[v], dats[v]);
         out_ready = 1'b1;
         #1;
         total++;
         if (req_ready !== oh) begin bad++; $display("FAIL single_ready[%0d] got=%b want=%b", v, req_ready, oh); end
         @(negedge clk);
         req_valid = '0;
         #1;
         total++;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early[%0d] got=%b want=0", v, out_valid); end
         @(negedge clk);
         #1;
         total++;
         if (out_valid !== 1'b1 || out_data !== exps[v] || out_id !== 2'(ids[v]) || out_zero !== zers[v]) begin
            bad++;
            $display("FAIL single_result[%0d] got v=%b d=%h id=%0d z=%b want v=1 d=%h id=%0d z=%b",
                     v, out_valid, out_data, out_id, out_zero, exps[v], ids[v], zers[v]);
         end
      end
   endtask

   task automatic test_rotation();
      logic [3:0] oh;
      int         k;
      do_reset();
      load_table();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         req_valid = 4'hF;
         out_ready = 1'b1;
         #1;
         oh = 4'b0001 << (c % 4);
         total++;
         if (req_ready !== oh) begin bad++; $display("FAIL rot_ready[%0d] got=%b want=%b", c, req_ready, oh); end
         if (c >= 2) begin
            k = (c - 2) % 4;
            total++;
            if (out_valid !== 1'b1 || out_id !== 2'(k) || out_data !== etab[k] || out_zero !== ztab[k]) begin
               bad++;
               $display("FAIL rot_out[%0d] got v=%b id=%0d d=%h z=%b want v=1 id=%0d d=%h z=%b",
                        c, out_valid, out_id, out_data, out_zero, k, etab[k], ztab[k]);
            end
         end
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      int accepts;
      int k;
      do_reset();
      load_table();
      // One word from requester 0 while the consumer is stalled.
      @(negedge clk);
      req_valid = 4'b0001;
      out_ready = 1'b0;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_first got=%b want=0001", req_ready); end
      @(negedge clk);
      req_valid = '0;
      // Stage 2 is now full and stage 1 empty: all requesters ask for 5 cycles.
      accepts = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         req_valid = 4'hF;
         #1;
         if (req_ready != 4'h0) begin
            accepts++;
            total++;
            if (req_ready !== 4'b0010 || c != 0) begin
               bad++; $display("FAIL bp_grant cycle=%0d got=%b want=0010 at cycle 0", c, req_ready);
            end
         end
         total++;
         if (out_valid !== 1'b1 || out_data !== 19'h40000 || out_id !== 2'd0) begin
            bad++; $display("FAIL bp_hold[%0d] got v=%b d=%h id=%0d want v=1 d=40000 id=0", c, out_valid, out_data, out_id);
         end
      end
      total++;
      if (accepts != 1) begin bad++; $display("FAIL bp_accepts got=%0d want=1", accepts); end
      // Release: results continue 0,1,2,3,0,1 without gaps or repeats.
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_valid = 4'hF;
         out_ready = 1'b1;
         #1;
         k = c % 4;
         total++;
         if (out_valid !== 1'b1 || out_id !== 2'(k) || out_data !== etab[k]) begin
            bad++; $display("FAIL bp_release[%0d] got v=%b id=%0d d=%h want v=1 id=%0d d=%h", c, out_valid, out_id, out_data, k, etab[k]);
         end
      end
      req_valid = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      load_table();
      @(negedge clk);
      req_valid = 4'hF;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      total++;
      if (busy !== 1'b1 || out_valid !== 1'b1 || req_ready !== 4'h0) begin
         bad++; $display("FAIL mid_full got busy=%b v=%b rdy=%b want 1/1/0000", busy, out_valid, req_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if (req_ready !== 4'h0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0000", req_ready); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL mid_cleared got v=%b busy=%b want 0/0", out_valid, busy);
      end
      total++;
      if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant got=%b want=0001", req_ready); end
      req_valid = '0;
   endtask

   typedef struct packed {
      logic [1:0]  id;
      logic [17:0] data;
   } item_t;

   task automatic test_random();
      item_t       q[$];
      item_t       it;
      int          mptr   = 0;
      int          nacc   = 0;
      int          nout   = 0;
      int          cycles = 0;
      int          g;
      logic [3:0]  oh;
      logic [19:0] r;
      logic [17:0] w;
      do_reset();
      while (nout < NWORDS && cycles < LIMIT) begin
         @(negedge clk);
         cycles++;
         for (int i = 0; i < 4; i++) begin
            req_valid[i] = (nacc < NWORDS) && ($urandom_range(0, 9) < 6);
            w[11:0]  = 12'($urandom_range(0, 4095));
            w[17:12] = ($urandom_range(0, 3) != 0) ? 6'(-$urandom_range(0, 18)) : 6'($urandom_range(0, 63));
            set_word(i, w);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (req_valid != 4'h0) begin
            g = -1;
            for (int o = 0; o < 4; o++)
               if (g < 0 && req_valid[(mptr + o) % 4]) g = (mptr + o) % 4;
            oh = 4'b0001 << g;
            total++;
            if (req_ready != 4'h0) begin
               if (req_ready !== oh) begin bad++; $display("FAIL rnd_grant got=%b want=%b", req_ready, oh); end
               it.id   = 2'(g);
               it.data = req_data[g*18 +: 18];
               q.push_back(it);
               mptr = (g + 1) % 4;
               nacc++;
            end else if (!(out_valid && !out_ready)) begin
               bad++; $display("FAIL rnd_nogrant got=%b want=%b", req_ready, oh);
            end
         end
         if (out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
               bad++; $display("FAIL rnd_spurious got id=%0d want no output", out_id);
            end else begin
               it = q.pop_front();
               r  = ref_alog(it.data);
               if (out_id !== it.id || out_data !== r[18:0] || out_zero !== r[19]) begin
                  bad++;
                  $display("FAIL rnd_out in=%h got id=%0d d=%h z=%b want id=%0d d=%h z=%b",
                           it.data, out_id, out_data, out_zero, it.id, r[18:0], r[19]);
               end
            end
            nout++;
         end
      end
      req_valid = '0;
      total++;
      if (cycles >= LIMIT || q.size() != 0 || nacc != NWORDS) begin
         bad++; $display("FAIL rnd_complete got acc=%0d out=%0d pending=%0d want %0d/%0d/0", nacc, nout, q.size(), NWORDS, NWORDS);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_alog_share_arb
`default_nettype wire
